// File: rtl/trace_pkg.sv
// Shared types and constants for the PC trace buffer.
package trace_pkg;

    localparam int SEQ_W = 16;

    typedef enum logic [1:0] {IDLE, ARMED, RUN, FROZEN} state_t;

endpackage

// File: rtl/trace_fifo.sv
// Record storage for the trace buffer: show-ahead FIFO that either drops or
// overwrites the oldest record when full, with a sticky overflow flag.
module trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int WRAP  = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_pop;
    logic             do_push;
    logic             overwrite;
    logic             drop;

    // A pop in the same cycle frees a slot, so a full buffer can still accept a push.
    always_comb begin
        full      = (count == (AW+1)'(DEPTH));
        do_pop    = pop && (count != '0);
        do_push   = push && (!full || do_pop || WRAP != 0);
        overwrite = do_push && full && !do_pop;
        drop      = push && !do_push;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop || overwrite)
                rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop && !full)
                count <= count + (AW+1)'(1);
            else if (do_pop && !do_push)
                count <= count - (AW+1)'(1);
            if (overwrite || drop)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear)
            mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/pc_trace_buffer.sv
// PC trace buffer: captures the fetch PC plus masked register snapshots whenever
// the PC changes while armed/running, and presents the oldest record for readout.
module pc_trace_buffer
    import trace_pkg::*;
#(
    parameter int PC_W   = 32,
    parameter int DATA_W = 32,
    parameter int NCH    = 5,
    parameter int DEPTH  = 16,
    parameter int WRAP   = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    arm,
    input  logic                    stop,
    input  logic                    clear,
    input  logic [PC_W-1:0]         pc_in,
    input  logic [NCH*DATA_W-1:0]   ch_in,
    input  logic [NCH-1:0]          ch_mask,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [PC_W-1:0]         rd_pc,
    output logic [NCH*DATA_W-1:0]   rd_data,
    output logic [SEQ_W-1:0]        rd_seq,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    busy
);

    localparam int CH_W  = NCH * DATA_W;
    localparam int REC_W = PC_W + CH_W + SEQ_W;

    state_t           state;
    logic [PC_W-1:0]  last_pc;
    logic [SEQ_W-1:0] seq_cnt;
    logic [CH_W-1:0]  masked;
    logic [REC_W-1:0] wr_rec;
    logic [REC_W-1:0] rd_rec;
    logic             full;
    logic             cap_try;
    logic             cap_ok;

    always_comb begin
        masked = '0;
        for (int k = 0; k < NCH; k++)
            if (ch_mask[k])
                masked[k*DATA_W +: DATA_W] = ch_in[k*DATA_W +: DATA_W];
    end

    // Clear and stop both suppress capture; a full non-wrapping buffer only
    // accepts when a pop frees a slot in the same cycle.
    assign cap_try  = !clear && !stop &&
                      ((state == ARMED) || (state == RUN && pc_in != last_pc));
    assign cap_ok   = cap_try && (!full || (rd_valid && rd_ready) || WRAP != 0);
    assign wr_rec   = {pc_in, masked, seq_cnt};
    assign rd_valid = (count != '0);
    assign {rd_pc, rd_data, rd_seq} = rd_rec;

    trace_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH),
        .WRAP  (WRAP)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .push     (cap_try),
        .pop      (rd_ready),
        .wr_data  (wr_rec),
        .rd_data  (rd_rec),
        .count    (count),
        .full     (full),
        .overflow (overflow)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            last_pc <= '0;
            seq_cnt <= '0;
        end else begin
            if (clear)
                seq_cnt <= '0;
            else if (cap_ok) begin
                seq_cnt <= seq_cnt + SEQ_W'(1);
                last_pc <= pc_in;
            end

            if (stop) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (arm) begin
                            state <= ARMED;
                            busy  <= 1'b1;
                        end
                    end
                    ARMED, RUN: begin
                        if (cap_try) begin
                            state <= cap_ok ? RUN : FROZEN;
                            busy  <= cap_ok;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pc_trace_buffer.sv
// Self-checking bench: a non-wrapping and a wrapping DEPTH=4 instance share
// stimulus and are compared against a queue-based model of the record stream.
module tb_pc_trace_buffer;

    localparam int DEPTH = 4;
    localparam int S_IDLE = 0, S_ARMED = 1, S_RUN = 2, S_FROZEN = 3;

    typedef struct packed {
        logic [31:0]  pc;
        logic [159:0] data;
        logic [15:0]  seq;
    } rec_t;

    logic         clk = 1'b0;
    logic         reset, arm, stop, clear, rd_ready;
    logic [31:0]  pc_in;
    logic [159:0] ch_in;
    logic [4:0]   ch_mask;

    logic [1:0]   rd_valid, overflow, busy;
    logic [31:0]  rd_pc   [2];
    logic [159:0] rd_data [2];
    logic [15:0]  rd_seq  [2];
    logic [2:0]   count   [2];

    int checks = 0;
    int failures = 0;

    rec_t        mq [2][$];
    int          mst [2];
    bit          movf [2];
    logic [15:0] mseq [2];
    logic [31:0] mlast [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        pc_trace_buffer #(
            .PC_W(32), .DATA_W(32), .NCH(5), .DEPTH(DEPTH), .WRAP(g)
        ) dut (
            .clk(clk), .reset(reset), .arm(arm), .stop(stop), .clear(clear),
            .pc_in(pc_in), .ch_in(ch_in), .ch_mask(ch_mask),
            .rd_valid(rd_valid[g]), .rd_ready(rd_ready), .rd_pc(rd_pc[g]),
            .rd_data(rd_data[g]), .rd_seq(rd_seq[g]), .count(count[g]),
            .overflow(overflow[g]), .busy(busy[g])
        );
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [159:0] mask_channels(input logic [159:0] ch, input logic [4:0] m);
        logic [159:0] r;
        r = '0;
        for (int k = 0; k < 5; k++)
            if (m[k]) r[k*32 +: 32] = ch[k*32 +: 32];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mq[i].delete();
            mst[i] = S_IDLE;
            movf[i] = 1'b0;
            mseq[i] = '0;
            mlast[i] = '0;
        end
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            bit attempt;
            bit captured;
            rec_t r;
            attempt = !clear && !stop &&
                      (mst[i] == S_ARMED || (mst[i] == S_RUN && pc_in != mlast[i]));
            captured = 1'b0;
            if (clear) begin
                mq[i].delete();
                movf[i] = 1'b0;
                mseq[i] = '0;
            end else begin
                if (rd_ready && mq[i].size() > 0) void'(mq[i].pop_front());
                if (attempt) begin
                    if (mq[i].size() < DEPTH || i == 1) begin
                        if (mq[i].size() == DEPTH) begin
                            void'(mq[i].pop_front());
                            movf[i] = 1'b1;
                        end
                        r.pc = pc_in;
                        r.data = mask_channels(ch_in, ch_mask);
                        r.seq = mseq[i];
                        mq[i].push_back(r);
                        mseq[i] = mseq[i] + 16'd1;
                        mlast[i] = pc_in;
                        captured = 1'b1;
                    end else begin
                        movf[i] = 1'b1;
                    end
                end
            end
            if (stop) mst[i] = S_IDLE;
            else if (mst[i] == S_IDLE && arm) mst[i] = S_ARMED;
            else if ((mst[i] == S_ARMED || mst[i] == S_RUN) && attempt)
                mst[i] = captured ? S_RUN : S_FROZEN;
        end
    endtask

    task automatic check_output();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("u%0d.count", i), 256'(count[i]), 256'(mq[i].size()));
            check($sformatf("u%0d.rd_valid", i), 256'(rd_valid[i]), 256'(mq[i].size() > 0));
            check($sformatf("u%0d.overflow", i), 256'(overflow[i]), 256'(movf[i]));
            check($sformatf("u%0d.busy", i), 256'(busy[i]),
                  256'(mst[i] == S_ARMED || mst[i] == S_RUN));
            if (mq[i].size() > 0) begin
                check($sformatf("u%0d.rd_pc", i), 256'(rd_pc[i]), 256'(mq[i][0].pc));
                check($sformatf("u%0d.rd_data", i), 256'(rd_data[i]), 256'(mq[i][0].data));
                check($sformatf("u%0d.rd_seq", i), 256'(rd_seq[i]), 256'(mq[i][0].seq));
            end
        end
    endtask

    task automatic step_cycle();
        model_step();
        @(posedge clk);
        #1;
        check_output();
    endtask

    task automatic rand_ch();
        ch_in = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    initial begin
        logic [31:0] pcs029 [5];
        logic [31:0] exp029 [4];
        pcs029 = '{32'd0, 32'd4, 32'd8, 32'd8, 32'd12};
        exp029 = '{32'd0, 32'd4, 32'd8, 32'd12};

        arm = 0; stop = 0; clear = 0; rd_ready = 0;
        pc_in = 0; ch_in = 0; ch_mask = 5'b11111; reset = 0;
        model_reset();
        #2;
        check_output();
        @(posedge clk);
        #1;
        reset = 1;

        // Basic capture with a repeated PC.
        arm = 1; step_cycle(); arm = 0;
        for (int k = 0; k < 5; k++) begin
            pc_in = pcs029[k]; rand_ch(); step_cycle();
        end
        check("basic.count", 256'(count[0]), 256'(4));
        check("basic.first_seq", 256'(rd_seq[0]), 256'(0));
        rd_ready = 1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("basic.pc%0d", k), 256'(rd_pc[0]), 256'(exp029[k]));
            check($sformatf("basic.seq%0d", k), 256'(rd_seq[0]), 256'(k));
            step_cycle();
        end
        rd_ready = 0;

        // Fill past capacity: instance 0 freezes, instance 1 overwrites.
        stop = 1; step_cycle(); stop = 0;
        clear = 1; step_cycle(); clear = 0;
        arm = 1; step_cycle(); arm = 0;
        for (int k = 0; k < 6; k++) begin
            pc_in = 32'(4 * k); rand_ch(); step_cycle();
        end
        check("full.count0", 256'(count[0]), 256'(4));
        check("full.ovf0", 256'(overflow[0]), 256'(1));
        check("full.busy0", 256'(busy[0]), 256'(0));
        check("full.pc0", 256'(rd_pc[0]), 256'(0));
        check("wrap.count1", 256'(count[1]), 256'(4));
        check("wrap.pc1", 256'(rd_pc[1]), 256'(8));
        check("wrap.seq1", 256'(rd_seq[1]), 256'(2));
        check("wrap.ovf1", 256'(overflow[1]), 256'(1));
        arm = 1; step_cycle(); arm = 0;
        check("frozen.ignores_arm", 256'(busy[0]), 256'(0));
        rd_ready = 1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("frozen.pc%0d", k), 256'(rd_pc[0]), 256'(4 * k));
            check($sformatf("wrap.seq%0d", k), 256'(rd_seq[1]), 256'(k + 2));
            step_cycle();
        end
        rd_ready = 0;

        // Pop and capture together on a full buffer.
        stop = 1; step_cycle(); stop = 0;
        clear = 1; step_cycle(); clear = 0;
        arm = 1; step_cycle(); arm = 0;
        for (int k = 0; k < 4; k++) begin
            pc_in = 32'(100 + 4 * k); rand_ch(); step_cycle();
        end
        rd_ready = 1; pc_in = 116; rand_ch(); step_cycle(); rd_ready = 0;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("popcap.count%0d", i), 256'(count[i]), 256'(4));
            check($sformatf("popcap.ovf%0d", i), 256'(overflow[i]), 256'(0));
            check($sformatf("popcap.pc%0d", i), 256'(rd_pc[i]), 256'(104));
        end

        // Channel masking.
        clear = 1; step_cycle(); clear = 0;
        pc_in = 200; ch_in = '1; ch_mask = 5'b00101; step_cycle();
        for (int i = 0; i < 2; i++)
            check($sformatf("mask.data%0d", i), 256'(rd_data[i]),
                  256'({32'h0, 32'h0, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF}));
        ch_mask = 5'b11111;

        // Randomised traffic against the model.
        for (int n = 0; n < 400; n++) begin
            arm = ($urandom_range(0, 7) == 0);
            stop = ($urandom_range(0, 15) == 0);
            clear = ($urandom_range(0, 31) == 0);
            rd_ready = ($urandom_range(0, 2) == 0);
            pc_in = 32'(4 * $urandom_range(0, 5));
            ch_mask = 5'($urandom());
            rand_ch();
            step_cycle();
        end

        // Asynchronous reset mid-run, then clear racing a capture.
        arm = 0; stop = 1; clear = 0; rd_ready = 0; ch_mask = 5'b11111;
        step_cycle(); stop = 0;
        clear = 1; step_cycle(); clear = 0;
        arm = 1; step_cycle(); arm = 0;
        pc_in = 300; step_cycle();
        pc_in = 304; step_cycle();
        check("prereset.count", 256'(count[0]), 256'(2));
        reset = 0;
        model_reset();
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("areset.rd_valid%0d", i), 256'(rd_valid[i]), 256'(0));
            check($sformatf("areset.busy%0d", i), 256'(busy[i]), 256'(0));
        end
        check_output();
        reset = 1;
        arm = 1; step_cycle(); arm = 0;
        pc_in = 400; step_cycle();
        pc_in = 404; clear = 1; step_cycle(); clear = 0;
        for (int i = 0; i < 2; i++)
            check($sformatf("clearcap.count%0d", i), 256'(count[i]), 256'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_trace_buffer.md
PC_TRACE_BUFFER -- requirements
Module: pc_trace_buffer

Interface
REQ-001 SHALL have parameter PC_W, default 32, meaning PC width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning width of one register channel.
REQ-003 SHALL have parameter NCH, default 5, meaning number of snooped register channels (1..16).
REQ-004 SHALL have parameter DEPTH, default 16, meaning record capacity (power of 2, >=2).
REQ-005 SHALL have parameter WRAP, default 0, meaning 0 = stop when full, 1 = overwrite oldest.
REQ-006 SHALL have ports: clk  in  1  rising-edge clock, the only clock domain.
REQ-007 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-008 SHALL have ports: arm in 1 start capture; stop in 1 end capture; clear in 1 flush buffer; pc_in in PC_W fetch-stage PC; ch_in in NCH*DATA_W register snapshots, channel k at bits [k*DATA_W +: DATA_W]; ch_mask in NCH per-channel enable.
REQ-009 SHALL have outputs: rd_valid out 1; rd_ready in 1; rd_pc out PC_W; rd_data out NCH*DATA_W; rd_seq out 16 record sequence number; count out log2(DEPTH)+1 occupancy; overflow out 1 sticky; busy out 1 high in ARMED/RUN.

Function
REQ-010 SHALL implement states IDLE, ARMED, RUN, FROZEN.
REQ-011 IDLE->ARMED on arm; ARMED->RUN on first capture; RUN->FROZEN when full with WRAP=0 and a capture is attempted; any of ARMED/RUN/FROZEN->IDLE on stop.
REQ-012 ARMED SHALL capture unconditionally in its first cycle, regardless of pc_in.
REQ-013 RUN SHALL capture in any cycle where pc_in differs from last_pc, the PC of the previous capture.
REQ-014 Capture SHALL store pc_in, ch_in with masked-off channels forced to zero, and seq_cnt; seq_cnt SHALL then increment, wrapping 16'hFFFF->0.
REQ-015 A captured record SHALL appear on rd_* the cycle after the capturing edge (1-cycle latency).
REQ-016 rd_* SHALL show the oldest record (show-ahead); rd_valid = (count != 0); pop SHALL occur on rd_valid && rd_ready.
REQ-017 Full with WRAP=1: a capture SHALL overwrite the oldest record, advance the read pointer, hold count at DEPTH, and set overflow.
REQ-018 Full with WRAP=0: a capture attempt SHALL be dropped, set overflow, and enter FROZEN.
REQ-019 Simultaneous pop and capture when full SHALL accept both; no overwrite; overflow unchanged; count unchanged.
REQ-020 Simultaneous pop and capture when empty SHALL perform the capture only; a pop on empty SHALL be ignored.
REQ-021 clear SHALL zero pointers, count, overflow and seq_cnt next edge; state unchanged; clear has priority over a capture or pop in the same cycle.
REQ-022 Priority among arm/stop in the same cycle: stop wins.
REQ-023 FROZEN and IDLE SHALL still allow pops; the buffer is retained until clear.
REQ-024 Pointers SHALL wrap modulo DEPTH.

Reset
REQ-025 Reset low SHALL force state IDLE, pointers/count/seq_cnt/last_pc = 0, overflow = 0, rd_valid = 0, busy = 0, immediately and independent of clk.
REQ-026 Reset asserted mid-capture SHALL discard all records; storage contents need not be cleared.

Structure
REQ-027 A shared package trace_pkg SHALL hold the state enum and the SEQ_W=16 constant.
REQ-028 Storage and pointers SHALL be a sub-module trace_fifo (parameters WIDTH, DEPTH, WRAP); the FSM, change detection and masking SHALL live in the top.

Verification
REQ-029 reset, arm, pc_in 0,4,8,8,12 -> 4 records: PCs 0,4,8,12; seq 0..3; count=4.
REQ-030 DEPTH=4, WRAP=0, 6 distinct PCs with rd_ready=0 -> count=4, overflow=1, state FROZEN, records PC 0..12.
REQ-031 DEPTH=4, WRAP=1, PCs 0,4,...,20 -> count=4, oldest rd_pc=8, seq 2..5, overflow=1.
REQ-032 ch_mask=5'b00101, ch_in all 32'hFFFFFFFF -> rd_data has only channels 0 and 2 = FFFFFFFF; others 0.
REQ-033 Full buffer, rd_ready=1, new PC in the same cycle -> count stays DEPTH, overflow stays 0.
REQ-034 Reset low for 1 ns between edges mid-RUN -> rd_valid=0, busy=0 immediately; clear+capture in the same cycle -> count=0.
